// File: rtl/ndigit_7segm_scan.sv
// ndigit_7segm_scan: N-digit multiplexed 7-segment BCD display scanner.
// Double-buffered display data with frame-aligned update.
//
// Parameters:
//   NDIGITS  - number of multiplexed digits (1..8)
//   PRESCALE - clock cycles each digit stays selected (2..65536)
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   bcd_in       - packed BCD, digit k at [4k+3:4k]
//   load         - capture bcd_in this cycle
//   LED_type_ctl - 1 = common cathode, 0 = common anode
//   seg_out      - {a,b,c,d,e,f,g}, registered
//   an_out       - one-hot digit select, registered
//   frame_sync   - one-cycle pulse after index wraps to 0
// Build option:
//   LEADING_ZERO_BLANK_EN - blank zero digits above the most
//   significant non-zero digit (digit 0 always shown).
module ndigit_7segm_scan #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  input  logic                   load,
  input  logic                   LED_type_ctl,
  output logic [6:0]             seg_out,
  output logic [NDIGITS-1:0]     an_out,
  output logic                   frame_sync
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IMAX = IW'(NDIGITS - 1);

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
  logic [4*NDIGITS-1:0]   disp_q, disp_d;
  logic                   pend_q, pend_d;
  logic [6:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic                   fs_q, fs_d;

  logic                   tick;
  logic                   wrap;
  logic [3:0]             cur;
  logic                   blk;
  logic [NDIGITS-1:0]     blank_v;
  logic [NDIGITS-1:0]     an_hot;
  logic [6:0]             code;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Scan counters and double-buffered data
  always_comb begin
    tick     = (presc_q == PMAX);
    wrap     = tick && (idx_q == IMAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IMAX) ? '0 : idx_q + 1'b1;
    end
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (load) begin
      shadow_d = bcd_in;
    end
    // Display data only changes at a frame boundary; a load on
    // the boundary itself bypasses the shadow.
    if (wrap) begin
      if (load) begin
        disp_d = bcd_in;
      end else if (pend_q) begin
        disp_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end
  end

  // Leading-zero mask: bit k set when digits k..top are all zero
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic run;
    run     = 1'b1;
    blank_v = '0;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      run        = run && (disp_q[4*k +: 4] == 4'd0);
      blank_v[k] = run;
    end
  end
`else
  assign blank_v = '0;
`endif

  // Current digit select and output encode
  always_comb begin
    cur    = '0;
    blk    = 1'b0;
    an_hot = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur       = disp_q[4*k +: 4];
        blk       = blank_v[k];
        an_hot[k] = 1'b1;
      end
    end
    code  = blk ? 7'b0000000 : seg7(cur);
    seg_d = LED_type_ctl ? code : ~code;
    an_d  = LED_type_ctl ? ~an_hot : an_hot;
    fs_d  = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      seg_q    <= '0;
      an_q     <= '0;
      fs_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_sync = fs_q;

endmodule

// File: tb/tb_ndigit_7segm_scan.sv
// tb_ndigit_7segm_scan: directed bench for ndigit_7segm_scan
// (NDIGITS=4, PRESCALE=4).
module tb_ndigit_7segm_scan;

  localparam int ND = 4;
  localparam int PS = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZEXP = 7'b0000000;
  localparam logic [6:0] ZEXPA = 7'b1111111;
`else
  localparam logic [6:0] ZEXP = 7'b1111110;
  localparam logic [6:0] ZEXPA = 7'b0000001;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   bcd_in = '0;
  logic          load = 1'b0;
  logic          led = 1'b1;
  logic [6:0]    seg_out;
  logic [ND-1:0] an_out;
  logic          frame_sync;

  int checks = 0;
  int fails = 0;
  int cyc;

  ndigit_7segm_scan #(.NDIGITS(ND), .PRESCALE(PS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bcd_in(bcd_in),
    .load(load),
    .LED_type_ctl(led),
    .seg_out(seg_out),
    .an_out(an_out),
    .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  // Advance to the falling edge after rising edge n
  task automatic goto(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      checks++;
      fails++;
      $display("FAIL goto cyc=%0d want %0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_out !== 7'b0) begin
      fails++;
      $display("FAIL rst_seg got %b want 0000000", seg_out);
    end
    checks++;
    if (an_out !== 4'b0) begin
      fails++;
      $display("FAIL rst_an got %b want 0000", an_out);
    end
    checks++;
    if (frame_sync !== 1'b0) begin
      fails++;
      $display("FAIL rst_fs got %b want 0", frame_sync);
    end
    rst_n = 1'b1;
    goto(1);
    checks++;
    if (seg_out !== 7'b1111110) begin
      fails++;
      $display("FAIL first_seg got %b want 1111110", seg_out);
    end
    checks++;
    if (an_out !== 4'b1110) begin
      fails++;
      $display("FAIL first_an got %b want 1110", an_out);
    end
  endtask

  task automatic test_frame_sync();
    for (int n = 2; n <= 17; n++) begin
      goto(n);
      checks++;
      if (frame_sync !== (n == 16)) begin
        fails++;
        $display("FAIL fs_cyc%0d got %b want %b",
                 n, frame_sync, (n == 16));
      end
    end
  endtask

  task automatic test_load();
    goto(17);
    bcd_in = 16'h1234;
    load = 1'b1;
    goto(18);
    load = 1'b0;
    goto(34);
    checks++;
    if (seg_out !== 7'b0110011 || an_out !== 4'b1110) begin
      fails++;
      $display("FAIL load_d0 got %b/%b want 0110011/1110",
               seg_out, an_out);
    end
    goto(46);
    checks++;
    if (seg_out !== 7'b0110000 || an_out !== 4'b0111) begin
      fails++;
      $display("FAIL load_d3 got %b/%b want 0110000/0111",
               seg_out, an_out);
    end
    goto(48);
    checks++;
    if (frame_sync !== 1'b1) begin
      fails++;
      $display("FAIL load_fs got %b want 1", frame_sync);
    end
  endtask

  task automatic test_polarity();
    goto(49);
    led = 1'b0;
    goto(50);
    checks++;
    if (seg_out !== 7'b1001100 || an_out !== 4'b0001) begin
      fails++;
      $display("FAIL anode_d0 got %b/%b want 1001100/0001",
               seg_out, an_out);
    end
    led = 1'b1;
    goto(51);
    checks++;
    if (seg_out !== 7'b0110011 || an_out !== 4'b1110) begin
      fails++;
      $display("FAIL cathode_back got %b/%b want 0110011/1110",
               seg_out, an_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ans [4];
    ans[0] = 4'b1110;
    ans[1] = 4'b1101;
    ans[2] = 4'b1011;
    ans[3] = 4'b0111;
    goto(53);
    bcd_in = 16'h5678;
    load = 1'b1;
    goto(54);
    bcd_in = 16'h9999;
    goto(55);
    load = 1'b0;
    bcd_in = '0;
    goto(58);
    checks++;
    if (seg_out !== 7'b1101101 || an_out !== 4'b1011) begin
      fails++;
      $display("FAIL b2b_old_d2 got %b/%b want 1101101/1011",
               seg_out, an_out);
    end
    goto(62);
    checks++;
    if (seg_out !== 7'b0110000 || an_out !== 4'b0111) begin
      fails++;
      $display("FAIL b2b_old_d3 got %b/%b want 0110000/0111",
               seg_out, an_out);
    end
    for (int d = 0; d < 4; d++) begin
      goto(66 + 4 * d);
      checks++;
      if (seg_out !== 7'b1111011 || an_out !== ans[d]) begin
        fails++;
        $display("FAIL b2b_new_d%0d got %b/%b want 1111011/%b",
                 d, seg_out, an_out, ans[d]);
      end
    end
  endtask

  task automatic test_wrap_load();
    logic [6:0] exp_s [4];
    logic [3:0] ans [4];
    exp_s[0] = 7'b0000001;
    exp_s[1] = 7'b0000001;
    exp_s[2] = ZEXP;
    exp_s[3] = ZEXP;
    ans[0] = 4'b1110;
    ans[1] = 4'b1101;
    ans[2] = 4'b1011;
    ans[3] = 4'b0111;
    goto(79);
    bcd_in = 16'h00AB;
    load = 1'b1;
    goto(80);
    load = 1'b0;
    bcd_in = '0;
    for (int d = 0; d < 4; d++) begin
      goto(82 + 4 * d);
      checks++;
      if (seg_out !== exp_s[d] || an_out !== ans[d]) begin
        fails++;
        $display("FAIL wrapload_d%0d got %b/%b want %b/%b",
                 d, seg_out, an_out, exp_s[d], ans[d]);
      end
    end
    goto(98);
    checks++;
    if (seg_out !== 7'b0000001) begin
      fails++;
      $display("FAIL wrapload_next got %b want 0000001", seg_out);
    end
  endtask

  task automatic test_blank();
    goto(100);
    bcd_in = 16'h0007;
    load = 1'b1;
    goto(101);
    load = 1'b0;
    bcd_in = '0;
    goto(114);
    checks++;
    if (seg_out !== 7'b1110000 || an_out !== 4'b1110) begin
      fails++;
      $display("FAIL blank_d0 got %b/%b want 1110000/1110",
               seg_out, an_out);
    end
    for (int d = 1; d < 4; d++) begin
      goto(114 + 4 * d);
      checks++;
      if (seg_out !== ZEXP) begin
        fails++;
        $display("FAIL blank_d%0d got %b want %b",
                 d, seg_out, ZEXP);
      end
    end
    goto(127);
    led = 1'b0;
    goto(128);
    checks++;
    if (seg_out !== ZEXPA || an_out !== 4'b1000) begin
      fails++;
      $display("FAIL blank_anode got %b/%b want %b/1000",
               seg_out, an_out, ZEXPA);
    end
    led = 1'b1;
  endtask

  task automatic test_reset_mid();
    goto(136);
    bcd_in = 16'h4321;
    load = 1'b1;
    goto(137);
    load = 1'b0;
    bcd_in = '0;
    goto(138);
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg_out !== 7'b0 || an_out !== 4'b0 || frame_sync !== 1'b0) begin
      fails++;
      $display("FAIL midrst_out got %b/%b/%b want 0/0/0",
               seg_out, an_out, frame_sync);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      goto(n);
      checks++;
      if (frame_sync !== (n == 16)) begin
        fails++;
        $display("FAIL midrst_fs%0d got %b want %b",
                 n, frame_sync, (n == 16));
      end
      if (n == 2) begin
        checks++;
        if (seg_out !== 7'b1111110 || an_out !== 4'b1110) begin
          fails++;
          $display("FAIL midrst_d0 got %b/%b want 1111110/1110",
                   seg_out, an_out);
        end
      end
      if (n == 6) begin
        checks++;
        if (seg_out !== ZEXP || an_out !== 4'b1101) begin
          fails++;
          $display("FAIL midrst_d1 got %b/%b want %b/1101",
                   seg_out, an_out, ZEXP);
        end
      end
    end
    goto(18);
    checks++;
    if (seg_out !== 7'b1111110) begin
      fails++;
      $display("FAIL midrst_pend got %b want 1111110", seg_out);
    end
  endtask

  initial begin
    test_reset();
    test_frame_sync();
    test_load();
    test_polarity();
    test_back_to_back();
    test_wrap_load();
    test_blank();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
